// File: rtl/cw_decoder_stream_buf.sv
// rtl/cw_decoder_stream_buf.sv - codeword FIFO, bit packer and message sequencer; CWD_LSB_FIRST_EN selects LSB-first packing
module cw_decoder_stream_buf #(
    parameter int CW_W   = 11,
    parameter int DEPTH  = 32,
    parameter int OUT_W  = 8,
    parameter int NUM_CW = 10
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     start,
    input  logic [CW_W-1:0]          cw_in,
    input  logic                     wr_en,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   data_count,
    output logic [CW_W-1:0]          core_word,
    output logic                     core_empty,
    input  logic                     core_rd,
    input  logic                     core_bit,
    input  logic                     core_bit_vld,
    input  logic                     core_cw_done,
    output logic                     core_hold,
    output logic [OUT_W-1:0]         msg_word,
    output logic                     msg_valid,
    input  logic                     msg_ready,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               err
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(OUT_W);
    localparam logic [BW-1:0] LAST_BIT  = BW'(OUT_W - 1);
    localparam logic [BW:0]   OUT_W_L   = (BW+1)'(OUT_W);
    localparam logic [7:0]    NUM_CW_M1 = 8'(NUM_CW - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    state_t state_q, state_d;

    logic [CW_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic            do_rd, do_wr;

    logic [OUT_W-1:0] shift_q, shift_d, shifted, padded;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic [BW:0]      pad_amt;
    logic [OUT_W-1:0] msg_word_q, msg_word_d;
    logic             msg_valid_q, msg_valid_d;
    logic [7:0]       cw_cnt_q, cw_cnt_d;
    logic [1:0]       err_q, err_d;
    logic             bit_last, out_free;

    // count never exceeds DEPTH, so its top bit alone marks full
    assign full       = count_q[AW];
    assign core_empty = (count_q == '0);
    assign data_count = count_q;
    assign core_word  = core_empty ? '0 : mem_q[rd_ptr_q];
    assign do_rd      = core_rd && !core_empty;
    assign do_wr      = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= cw_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign bit_last  = (bitcnt_q == LAST_BIT);
    assign out_free  = !msg_valid_q || msg_ready;
    assign core_hold = msg_valid_q && !msg_ready && bit_last;
    assign pad_amt   = OUT_W_L - {1'b0, bitcnt_q};

`ifdef CWD_LSB_FIRST_EN
    assign shifted = {core_bit, shift_q[OUT_W-1:1]};
    assign padded  = shift_q >> pad_amt;
`else
    assign shifted = {shift_q[OUT_W-2:0], core_bit};
    assign padded  = shift_q << pad_amt;
`endif

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;
        msg_word_d  = msg_word_q;
        msg_valid_d = msg_valid_q;
        cw_cnt_d    = cw_cnt_q;
        err_d       = err_q;

        if (wr_en && full && !do_rd) err_d[0] = 1'b1;
        if (msg_valid_q && msg_ready) msg_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    cw_cnt_d = '0;
                    bitcnt_d = '0;
                    shift_d  = '0;
                end
            end
            RUN: begin
                if (core_bit_vld) begin
                    if (core_hold) begin
                        err_d[1] = 1'b1;
                    end else if (bit_last) begin
                        shift_d     = shifted;
                        msg_word_d  = shifted;
                        msg_valid_d = 1'b1;
                        bitcnt_d    = '0;
                    end else begin
                        shift_d  = shifted;
                        bitcnt_d = bitcnt_q + BW'(1);
                    end
                end
                if (core_cw_done) begin
                    cw_cnt_d = cw_cnt_q + 8'd1;
                    if (cw_cnt_q == NUM_CW_M1) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (bitcnt_q == '0) begin
                    state_d = DONE;
                end else if (out_free) begin
                    msg_word_d  = padded;
                    msg_valid_d = 1'b1;
                    bitcnt_d    = '0;
                    state_d     = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            msg_word_q  <= '0;
            msg_valid_q <= 1'b0;
            cw_cnt_q    <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            msg_word_q  <= msg_word_d;
            msg_valid_q <= msg_valid_d;
            cw_cnt_q    <= cw_cnt_d;
            err_q       <= err_d;
        end
    end

    assign msg_word  = msg_word_q;
    assign msg_valid = msg_valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
endmodule

// File: tb/tb_cw_decoder_stream_buf.sv
// tb/tb_cw_decoder_stream_buf.sv - directed self-checking bench for cw_decoder_stream_buf
module tb_cw_decoder_stream_buf;
    localparam int CW_W = 11, DEPTH = 32, OUT_W = 8, NUM_CW = 10;

    logic              clk = 1'b0;
    logic              rst_b = 1'b0;
    logic              start = 1'b0;
    logic [CW_W-1:0]   cw_in = '0;
    logic              wr_en = 1'b0;
    logic              full;
    logic [5:0]        data_count;
    logic [CW_W-1:0]   core_word;
    logic              core_empty;
    logic              core_rd = 1'b0;
    logic              core_bit = 1'b0;
    logic              core_bit_vld = 1'b0;
    logic              core_cw_done = 1'b0;
    logic              core_hold;
    logic [OUT_W-1:0]  msg_word;
    logic              msg_valid;
    logic              msg_ready = 1'b0;
    logic              busy;
    logic              done;
    logic [1:0]        err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0]  w;
    logic [15:0] pat;

    cw_decoder_stream_buf #(.CW_W(CW_W), .DEPTH(DEPTH), .OUT_W(OUT_W), .NUM_CW(NUM_CW)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .cw_in(cw_in), .wr_en(wr_en),
        .full(full), .data_count(data_count), .core_word(core_word), .core_empty(core_empty),
        .core_rd(core_rd), .core_bit(core_bit), .core_bit_vld(core_bit_vld),
        .core_cw_done(core_cw_done), .core_hold(core_hold), .msg_word(msg_word),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
    endtask

    initial begin
        step();
        step();
        rst_b = 1'b1;
        chk("rst_count", data_count, 0);
        chk("rst_empty", core_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_word", core_word, 0);
        chk("rst_hold", core_hold, 0);
        chk("rst_msg_word", msg_word, 0);
        chk("rst_msg_valid", msg_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);

        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cw_in = CW_W'(i + 1);
            step();
        end
        wr_en = 1'b0;
        chk("pre_rst_count", data_count, 3);
        chk("pre_rst_head", core_word, 1);
        rst_pulse();
        chk("mid_rst_count", data_count, 0);
        chk("mid_rst_empty", core_empty, 1);
        chk("mid_rst_valid", msg_valid, 0);
        chk("mid_rst_busy", busy, 0);

        wr_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            cw_in = CW_W'(i);
            step();
        end
        chk("fill_full", full, 1);
        chk("fill_count", data_count, 32);
        chk("fill_err", err, 0);
        cw_in = 11'h7FF;
        step();
        wr_en = 1'b0;
        chk("ovf_full", full, 1);
        chk("ovf_count", data_count, 32);
        chk("ovf_err", err, 2'b01);
        core_rd = 1'b1;
        for (int i = 0; i < 32; i++) begin
            chk("ovf_pop", core_word, i);
            step();
        end
        core_rd = 1'b0;
        chk("drain_empty", core_empty, 1);
        chk("drain_count", data_count, 0);

        rst_pulse();
        wr_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            cw_in = CW_W'(i + 'h200);
            step();
        end
        cw_in   = 11'h055;
        core_rd = 1'b1;
        step();
        wr_en   = 1'b0;
        chk("rw_full_count", data_count, 32);
        chk("rw_full_full", full, 1);
        chk("rw_full_err", err, 0);
        for (int i = 1; i < 32; i++) begin
            chk("rw_pop", core_word, i + 'h200);
            step();
        end
        chk("rw_last", core_word, 'h055);
        step();
        core_rd = 1'b0;
        chk("rw_empty", core_empty, 1);

        rst_pulse();
        msg_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("pack_busy", busy, 1);
        for (int b = 0; b < 16; b++) begin
            core_bit = (b % 2 == 0);
            core_bit_vld = 1'b1;
            step();
            if (b == 6 || b == 14) chk("pack_not_yet", msg_valid, 0);
            if (b == 7 || b == 15) begin
                chk("pack_valid", msg_valid, 1);
                chk("pack_word", msg_word, 8'hAA);
            end
        end
        core_bit_vld = 1'b0;
        step();
        chk("pack_cleared", msg_valid, 0);

        msg_ready = 1'b0;
        pat = 16'hCCAA;
        for (int b = 0; b < 16; b++) begin
            core_bit = pat[15-b];
            core_bit_vld = 1'b1;
            step();
            if (b == 7) begin
                chk("bp_valid", msg_valid, 1);
                chk("bp_word", msg_word, 8'hCC);
            end
            if (b == 13) chk("bp_hold_14", core_hold, 0);
            if (b == 14) chk("bp_hold_15", core_hold, 1);
            if (b == 15) begin
                chk("bp_err", err, 2'b10);
                chk("bp_word_stable", msg_word, 8'hCC);
                chk("bp_hold_16", core_hold, 1);
            end
        end
        core_bit_vld = 1'b0;
        msg_ready = 1'b1;
        #1;
        chk("bp_hold_release", core_hold, 0);
        step();
        chk("bp_drained", msg_valid, 0);
        core_bit = 1'b1;
        core_bit_vld = 1'b1;
        step();
        core_bit_vld = 1'b0;
        chk("bp_next_valid", msg_valid, 1);
        chk("bp_next_word", msg_word, 8'hAB);
        step();
        chk("bp_next_clear", msg_valid, 0);
        chk("bp_err_sticky", err, 2'b10);

        rst_pulse();
        msg_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int b = 0; b < 83; b++) begin
            w = 8'((b / 8) * 37 + 5);
            if (b < 80) core_bit = w[7 - (b % 8)];
            else        core_bit = (b != 81);
            core_bit_vld = 1'b1;
            core_cw_done = ((b % 8 == 7) && (b < 72)) || (b == 82);
            step();
            if (b % 8 == 7 && b < 80) begin
                chk("msg_valid", msg_valid, 1);
                chk("msg_word", msg_word, w);
            end
        end
        core_bit_vld = 1'b0;
        core_cw_done = 1'b0;
        chk("end_flush_done", done, 0);
        chk("end_flush_busy", busy, 1);
        chk("end_flush_valid", msg_valid, 0);
        step();
        chk("end_tail_valid", msg_valid, 1);
        chk("end_tail_word", msg_word, 8'hA0);
        chk("end_done", done, 1);
        step();
        chk("end_done_clear", done, 0);
        chk("end_idle", busy, 0);
        chk("end_valid_clear", msg_valid, 0);
        chk("end_err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cw_decoder_stream_buf.md
Name: cw_decoder_stream_buf

Overview:
Parametrised front/back end for the constant-weight codeword decoder core. Contains a native synchronous FIFO, replacing the vendor IP. It presents buffered CW_W-bit codewords to the core and packs the core's serial binary output into OUT_W-bit words with a valid/ready handshake. It tracks codeword count per message and asserts done after NUM_CW codewords. Sits between the host byte interface and the decoder core, and supersedes the fixed 11-bit, depth-32, 10-word wrapper.

Parameters:
CW_W, 11, codeword width in bits
DEPTH, 32, FIFO depth in words; power of 2, minimum 2
OUT_W, 8, packed output word width in bits, 2..32
NUM_CW, 10, codewords per message, 1..255

Ports:
clk  in  1  rising-edge clock
rst_b  in  1  reset, synchronous, active-low
start  in  1  begin message; honoured only in IDLE
cw_in  in  CW_W  codeword from host
wr_en  in  1  host write strobe
full  out  1  FIFO full
data_count  out  $clog2(DEPTH)+1  FIFO occupancy
core_word  out  CW_W  FIFO head (first-word-fall-through)
core_empty  out  1  FIFO empty
core_rd  in  1  core pops head
core_bit  in  1  decoded message bit
core_bit_vld  in  1  core_bit valid this cycle
core_cw_done  in  1  one-cycle pulse per decoded codeword
core_hold  out  1  core must not assert core_bit_vld
msg_word  out  OUT_W  packed output word
msg_valid  out  1  msg_word valid
msg_ready  in  1  downstream accepts msg_word
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, message complete
err  out  2  sticky: [0] FIFO overflow, [1] packer overrun

Behaviour:
- Reset: rst_b low at a clock edge clears everything, including mid-operation: FIFO empty, data_count=0, full=0, core_empty=1, core_word=0, core_hold=0, msg_word=0, msg_valid=0, busy=0, done=0, err=0, state IDLE.
- FIFO write: accepted when wr_en && (!full || core_rd). A write at cycle t gives core_empty=0 and core_word valid at t+1.
- FIFO read: core_rd with core_empty=1 is ignored. There is no bypass, so a write into an empty FIFO is not readable in the same cycle.
- Simultaneous read and write when full: both occur; data_count is unchanged.
- Write when full without read: data is dropped and err[0] is set.
- Pointers wrap modulo DEPTH.
- FIFO writes are accepted in every state, so the host may prefetch.
- Packer: shift register plus bit counter (0..OUT_W-1). The first bit of each word lands in msg_word[OUT_W-1]; the packed word is MSB-first.
- On the OUT_W-th bit, the word transfers to the output register and msg_valid=1 the next cycle.
- msg_valid holds, and msg_word is stable, until msg_valid && msg_ready. Clear and reload in the same cycle is allowed.
- core_hold = msg_valid && !msg_ready && (bit counter == OUT_W-1).
- core_bit_vld while core_hold=1: the bit is dropped and err[1] is set.
- core_bit_vld outside RUN is ignored.
- State machine:
  - IDLE: start -> RUN; clear codeword counter and bit counter.
  - RUN: count core_cw_done; on the pulse that makes count == NUM_CW -> FLUSH. core_bit_vld in that same cycle is still packed.
  - FLUSH: if bit counter == 0 -> DONE. Otherwise wait until the output register is free, then load the partial word zero-padded in the low bits -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- start in any state other than IDLE is ignored.
- err bits clear only on reset.

Optional Feature:
CWD_LSB_FIRST_EN
- Defined: the first bit of each word lands in msg_word[0], and flush padding occupies the high bits.
- Undefined: MSB-first ordering as above.
- Handshake and timing are identical in both cases.

Test Plan:
- Reset defaults: write 3 words, then pulse rst_b low for 1 cycle -> data_count=0, core_empty=1, msg_valid=0, err=0, state IDLE.
- FIFO full/overflow, DEPTH=32: 33 writes with no reads -> full=1 after the 32nd, data_count=32, err[0]=1; pops return words 0..31 in order.
- Full boundary: with full=1, wr_en && core_rd in the same cycle -> data_count stays 32, err[0]=0, and the new word appears last.
- Packing: start, then 16 bits alternating 1,0 with no backpressure -> two words of 8'hAA. Each msg_valid is asserted the cycle after its 8th bit.
- Backpressure: msg_ready=0 and 15 bits sent -> core_hold=1 after the 15th. A 16th bit sent while held -> err[1]=1 and the bit is lost. msg_ready=1 -> core_hold drops.
- Message end, NUM_CW=10: 10 core_cw_done pulses with 83 total bits (MSB-first bit values 1,0,1 trailing) -> 10 full words, then final word 8'hA0. done pulses once, then busy=0.
